sw_trigger_gen: RTL and testbench
=================================

// Module: sw_trigger_gen
// PURPOSE
//   Consumes the raw SW input in the clk_320MHz domain and turns each clean press into a fixed-width trigger pulse.
//   Stages: 2-FF synchronizer, debounce filter, rising-edge detect, pulse/holdoff FSM.
//   trig_out drives downstream logic clocked by clk_320MHz (e.g. gating of the 160/80 MHz differential outputs).
// PARAMETERS
//   DEBOUNCE_CYCLES  3200000  cycles sw_sync must differ from sw_stable before sw_stable follows (10 ms); must be >= 2
//   PULSE_WIDTH      16       cycles trig_out stays high per pulse; must be >= 1
//   HOLDOFF_CYCLES   320      low cycles after a trigger before a new press is accepted; must be >= 1
//   CNT_W            16       width of trig_count
//   BURST_N          4        pulses per burst (TRIG_BURST_EN only); must be >= 1
//   BURST_GAP        8        low cycles between burst pulses (TRIG_BURST_EN only); must be >= 1
// PORTS
//   clk_320MHz  in   1      sole clock; all logic on rising edge
//   reset       in   1      synchronous, active-high
//   SW          in   1      raw asynchronous switch input
//   sw_stable   out  1      debounced switch level
//   trig_out    out  1      trigger pulse, registered
//   busy        out  1      high while FSM is not in IDLE, registered
//   overrun     out  1      sticky: a press arrived while busy; cleared only by reset
//   trig_count  out  CNT_W  number of accepted triggers; wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//   Reset: sw_meta, sw_sync, sw_stable, sw_stable_d, debounce counter, trig_out, busy, overrun, trig_count = 0; FSM = IDLE.
//   Sync: sw_meta <= SW; sw_sync <= sw_meta.
//   Debounce: if sw_sync == sw_stable, cnt <= 0.
//     Else if cnt == DEBOUNCE_CYCLES-1, sw_stable <= sw_sync and cnt <= 0; else cnt <= cnt+1.
//     Any bounce back to the sw_stable level before expiry restarts the count. Both edges are filtered identically.
//     Counter width: $clog2(DEBOUNCE_CYCLES).
//   Edge: sw_stable_d <= sw_stable; rise = sw_stable & ~sw_stable_d (combinational, one cycle wide). Falling edges are ignored.
//   Latency: if edge k is the first to sample SW=1, sw_stable is high after edge k+DEBOUNCE_CYCLES+1.
//     trig_out is high after edge k+DEBOUNCE_CYCLES+2.
//   FSM (states IDLE, PULSE, HOLDOFF; GAP with macro), with a single down-counter tcnt:
//     IDLE:    on rise -> PULSE, trig_out<=1, busy<=1, tcnt<=PULSE_WIDTH-1, trig_count<=trig_count+1.
//     PULSE:   tcnt==0 -> HOLDOFF, trig_out<=0, tcnt<=HOLDOFF_CYCLES-1; else tcnt--.
//     HOLDOFF: tcnt==0 -> IDLE, busy<=0; else tcnt--.
//     A rise in any state other than IDLE is dropped and sets overrun<=1.
//     trig_count is unchanged by a dropped rise.
//     A rise in the same cycle IDLE is re-entered (busy falls) is dropped, because the FSM is still in HOLDOFF that cycle.
//   trig_out is high for exactly PULSE_WIDTH consecutive cycles. Minimum trigger period is PULSE_WIDTH+HOLDOFF_CYCLES+1.
//   Reset mid-pulse or mid-holdoff: trig_out=0 and IDLE after the reset edge.
//     SW held high through reset re-triggers only after a full debounce from sw_stable=0.
// CONFIGURATION
//   TRIG_BURST_EN defined: each accepted press emits BURST_N pulses of PULSE_WIDTH cycles each.
//     Pulses are separated by BURST_GAP low cycles (state GAP), followed by HOLDOFF. A burst counter (reset 0) tracks pulses.
//     trig_count increments once per burst. busy stays high from the first pulse through the end of HOLDOFF.
//   TRIG_BURST_EN undefined: no GAP state, no burst counter, single pulse per press. BURST_N and BURST_GAP are unused.
// TESTING (DEBOUNCE_CYCLES=4, PULSE_WIDTH=3, HOLDOFF_CYCLES=5, CNT_W=4)
//   Clean press: SW 0->1 sampled at edge k -> trig_out high after edges k+6..k+8, low after k+9.
//     Also: busy low after k+14, trig_count=1.
//   Bounce: SW 1 for 2 cycles, 0 for 1, then 1 steady -> exactly one pulse, starting 6 edges after the final 0->1 sample.
//     Also: sw_stable never glitches.
//   Overrun: second clean press whose rise lands in HOLDOFF -> no second pulse, overrun=1, trig_count stays 1.
//   Release/short: SW 1->0 after a trigger -> no pulse. A 3-cycle SW high -> sw_stable stays 0, no pulse.
//   Wrap + reset: 16 accepted presses -> trig_count 15->0.
//     Reset asserted on the 2nd trig_out cycle -> trig_out=0, busy=0, overrun=0, trig_count=0 next cycle.
//   With TRIG_BURST_EN (BURST_N=2, BURST_GAP=2): one press -> high 3, low 2, high 3, then 5 holdoff cycles.
//     Also: trig_count=1.

Source files
------------

// File: rtl/sw_trigger_gen.sv
// -----------------------------------------------------------------------------
// sw_trigger_gen
//   Turns a raw, bouncing switch input into clean fixed-width trigger pulses
//   in the clk_320MHz domain.
//   Pipeline: 2-FF synchronizer -> debounce filter -> rising-edge detect ->
//   pulse/holdoff FSM.
//
// Ports
//   clk_320MHz  in   1      sole clock, rising edge
//   reset       in   1      synchronous, active-high
//   SW          in   1      raw asynchronous switch input
//   sw_stable   out  1      debounced switch level
//   trig_out    out  1      trigger pulse (registered), PULSE_WIDTH cycles
//   busy        out  1      high while the FSM is not idle (registered)
//   overrun     out  1      sticky: a press arrived while busy; reset clears it
//   trig_count  out  CNT_W  accepted triggers, wraps to 0
//
// Configuration
//   TRIG_BURST_EN  when defined, each accepted press emits BURST_N pulses
//                  separated by BURST_GAP low cycles, then the holdoff.
//                  When undefined, one pulse per press.
//
// Handshake: none. SW is a level input; every output is a level/pulse that
//   is valid every cycle, with no backpressure.
// -----------------------------------------------------------------------------
module sw_trigger_gen #(
    parameter int DEBOUNCE_CYCLES = 3200000,
    parameter int PULSE_WIDTH     = 16,
    parameter int HOLDOFF_CYCLES  = 320,
    parameter int CNT_W           = 16,
    parameter int BURST_N         = 4,
    parameter int BURST_GAP       = 8
) (
    input  logic             clk_320MHz,
    input  logic             reset,
    input  logic             SW,
    output logic             sw_stable,
    output logic             trig_out,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] trig_count
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // One shared down-counter for pulse, gap and holdoff. Its width is taken
    // from the full timing parameter set so it is the same in both builds.
    localparam int T_A   = (PULSE_WIDTH > HOLDOFF_CYCLES) ? PULSE_WIDTH : HOLDOFF_CYCLES;
    localparam int T_B   = (T_A > BURST_GAP) ? T_A : BURST_GAP;
    localparam int T_MAX = (T_B > BURST_N) ? T_B : BURST_N;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_PULSE   = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] T_HOLDOFF = TW'(HOLDOFF_CYCLES - 1);

`ifdef TRIG_BURST_EN
    localparam int            BW         = $clog2(BURST_N + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_N - 1);
    localparam logic [TW-1:0] T_GAP      = TW'(BURST_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_GAP     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;
`endif

    // Input conditioning
    logic            r_sw_meta;
    logic            r_sw_sync;
    logic            r_sw_stable;
    logic            r_sw_stable_d;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_rise;

    // FSM state and registered outputs
    state_t          r_state;
    logic [TW-1:0]   r_tcnt;
    logic            r_trig_out;
    logic            r_busy;
    logic            r_overrun;
    logic [CNT_W-1:0] r_trig_count;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_tcnt_nxt;
    logic            w_trig_nxt;
    logic            w_busy_nxt;
    logic            w_overrun_nxt;
    logic [CNT_W-1:0] w_count_nxt;

`ifdef TRIG_BURST_EN
    logic [BW-1:0]   r_burst;
    logic [BW-1:0]   w_burst_nxt;
`endif

    // -------------------------------------------------------------------------
    // Synchronizer, debounce and edge history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_320MHz) begin
        if (reset) begin
            r_sw_meta     <= 1'b0;
            r_sw_sync     <= 1'b0;
            r_sw_stable   <= 1'b0;
            r_sw_stable_d <= 1'b0;
            r_db_cnt      <= '0;
        end else begin
            r_sw_meta     <= SW;
            r_sw_sync     <= r_sw_meta;
            r_sw_stable_d <= r_sw_stable;
            // Any sample back at the stable level restarts the count, so only
            // an uninterrupted run of DEBOUNCE_CYCLES differing samples flips
            // the stable level. Both polarities use the same rule.
            if (r_sw_sync == r_sw_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_sw_stable <= r_sw_sync;
                r_db_cnt    <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // One-cycle strobe on the 0->1 transition of the debounced level.
    assign w_rise = r_sw_stable & ~r_sw_stable_d;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_320MHz) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            r_trig_out   <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
            r_trig_count <= '0;
`ifdef TRIG_BURST_EN
            r_burst      <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_trig_out   <= w_trig_nxt;
            r_busy       <= w_busy_nxt;
            r_overrun    <= w_overrun_nxt;
            r_trig_count <= w_count_nxt;
`ifdef TRIG_BURST_EN
            r_burst      <= w_burst_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state / next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_tcnt_nxt    = r_tcnt;
        w_trig_nxt    = r_trig_out;
        w_busy_nxt    = r_busy;
        w_count_nxt   = r_trig_count;
        // A press is only accepted from IDLE. This includes the cycle in
        // which HOLDOFF expires: the state is still HOLDOFF then, so a rise
        // landing exactly there is dropped and flagged.
        w_overrun_nxt = r_overrun | (w_rise & (r_state != ST_IDLE));
`ifdef TRIG_BURST_EN
        w_burst_nxt   = r_burst;
`endif

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PULSE;
                    w_trig_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_tcnt_nxt  = T_PULSE;
                    w_count_nxt = r_trig_count + CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (r_tcnt == '0) begin
                    w_trig_nxt = 1'b0;
`ifdef TRIG_BURST_EN
                    if (r_burst == BURST_LAST) begin
                        w_state_nxt = ST_HOLDOFF;
                        w_tcnt_nxt  = T_HOLDOFF;
                        w_burst_nxt = '0;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_tcnt_nxt  = T_GAP;
                        w_burst_nxt = r_burst + 1'b1;
                    end
`else
                    w_state_nxt = ST_HOLDOFF;
                    w_tcnt_nxt  = T_HOLDOFF;
`endif
                end else begin
                    w_tcnt_nxt = r_tcnt - 1'b1;
                end
            end

`ifdef TRIG_BURST_EN
            ST_GAP: begin
                if (r_tcnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_trig_nxt  = 1'b1;
                    w_tcnt_nxt  = T_PULSE;
                end else begin
                    w_tcnt_nxt = r_tcnt - 1'b1;
                end
            end
`endif

            ST_HOLDOFF: begin
                if (r_tcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_tcnt_nxt = r_tcnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_trig_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign sw_stable  = r_sw_stable;
    assign trig_out   = r_trig_out;
    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign trig_count = r_trig_count;

endmodule

// File: tb/tb_sw_trigger_gen.sv
// -----------------------------------------------------------------------------
// tb_sw_trigger_gen
//   Self-checking bench for sw_trigger_gen with DEBOUNCE_CYCLES=4,
//   PULSE_WIDTH=3, HOLDOFF_CYCLES=5, CNT_W=4 (BURST_N=2, BURST_GAP=2 when
//   TRIG_BURST_EN is defined).
//   Inputs are driven on the falling edge; outputs are sampled on the next
//   falling edge, after the reference model has consumed the rising edge.
// -----------------------------------------------------------------------------
module tb_sw_trigger_gen;

  localparam int D     = 4;
  localparam int PW    = 3;
  localparam int HO    = 5;
  localparam int CNT_W = 4;
`ifdef TRIG_BURST_EN
  localparam int BN = 2;
  localparam int BG = 2;
`else
  localparam int BN = 1;
  localparam int BG = 0;
`endif
  // Length of the pulse train and of the whole busy window, from acceptance.
  localparam int PULSE_SPAN = BN * PW + (BN - 1) * BG;
  localparam int BUSY_LEN   = PULSE_SPAN + HO;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             reset;
  logic             SW;
  logic             sw_stable;
  logic             trig_out;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] trig_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sw_trigger_gen #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_WIDTH     (PW),
    .HOLDOFF_CYCLES  (HO),
    .CNT_W           (CNT_W),
    .BURST_N         (2),
    .BURST_GAP       (2)
  ) dut (
    .clk_320MHz (clk),
    .reset      (reset),
    .SW         (SW),
    .sw_stable  (sw_stable),
    .trig_out   (trig_out),
    .busy       (busy),
    .overrun    (overrun),
    .trig_count (trig_count)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce rule: the stable level flips at edge n when the D raw samples
  // SW[n-2-D+1 .. n-2] (two cycles of synchronizer delay) all differ from it.
  // Trigger rule: a stable rise seen at edge n is accepted when more than
  // BUSY_LEN edges have passed since the last acceptance; the pulse train and
  // busy window are then fixed offsets from the acceptance edge.
  logic             m_hist[$];
  logic             m_stable   = 1'b0;
  logic             m_stable_d = 1'b0;
  int               m_n        = 0;
  int               m_last     = 0;
  bit               m_valid    = 1'b0;
  logic             m_overrun  = 1'b0;
  logic [CNT_W-1:0] m_count    = '0;

  task automatic model_edge(input logic sw_v, input logic rst_v);
    logic rise;
    bit   all_diff;
    m_n++;
    if (rst_v) begin
      m_hist.delete();
      for (int i = 0; i < D + 2; i++) m_hist.push_back(1'b0);
      m_stable   = 1'b0;
      m_stable_d = 1'b0;
      m_valid    = 1'b0;
      m_overrun  = 1'b0;
      m_count    = '0;
    end else begin
      rise = m_stable & ~m_stable_d;
      m_hist.push_back(sw_v);
      if (m_hist.size() > D + 3) void'(m_hist.pop_front());
      all_diff = 1'b1;
      for (int j = m_hist.size() - 2 - D; j <= m_hist.size() - 3; j++)
        if (m_hist[j] == m_stable) all_diff = 1'b0;
      m_stable_d = m_stable;
      if (all_diff) m_stable = ~m_stable;
      if (rise) begin
        if (!m_valid || (m_n - m_last) > BUSY_LEN) begin
          m_valid = 1'b1;
          m_last  = m_n;
          m_count = m_count + 1'b1;
        end else begin
          m_overrun = 1'b1;
        end
      end
    end
  endtask

  function automatic logic exp_trig();
    int d;
    if (!m_valid) return 1'b0;
    d = m_n - m_last;
    return (d < PULSE_SPAN) && ((d % (PW + BG)) < PW);
  endfunction

  function automatic logic exp_busy();
    if (!m_valid) return 1'b0;
    return (m_n - m_last) < BUSY_LEN;
  endfunction

  // ---------------- driver ----------------
  task automatic cyc(input logic sw_v, input logic rst_v);
    SW    = sw_v;
    reset = rst_v;
    @(posedge clk);
    model_edge(sw_v, rst_v);
    @(negedge clk);
    check("sw_stable", sw_stable, m_stable);
    check("trig_out", trig_out, exp_trig());
    check("busy", busy, exp_busy());
    check("overrun", overrun, m_overrun);
    check("trig_count", trig_count, m_count);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             sw;
    logic             rst;
    logic             e_stable;
    logic             e_trig;
    logic             e_busy;
    logic [CNT_W-1:0] e_count;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl[NV];

  int lat;
  int st_rises;
  int tr_rises;
  int st_high;
  logic prev_st;
  logic prev_tr;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    SW    = 1'b0;
    reset = 1'b1;

    // Clean press then release. Vector 0 is reset; vector 1 is edge k, the
    // first edge sampling SW=1; vector 23 is the first edge sampling SW=0.
    tbl[0] = '{sw: 1'b0, rst: 1'b1, e_stable: 1'b0, e_trig: 1'b0, e_busy: 1'b0, e_count: 4'd0};
    for (int i = 1; i < 23; i++) begin
      int j;
      j = i - 1;
      tbl[i].sw       = 1'b1;
      tbl[i].rst      = 1'b0;
      tbl[i].e_stable = (j >= 5);
`ifdef TRIG_BURST_EN
      tbl[i].e_trig   = (j >= 6 && j <= 8) || (j >= 11 && j <= 13);
      tbl[i].e_busy   = (j >= 6 && j <= 18);
`else
      tbl[i].e_trig   = (j >= 6 && j <= 8);
      tbl[i].e_busy   = (j >= 6 && j <= 13);
`endif
      tbl[i].e_count  = (j >= 6) ? 4'd1 : 4'd0;
    end
    for (int i = 23; i < NV; i++) begin
      tbl[i].sw       = 1'b0;
      tbl[i].rst      = 1'b0;
      tbl[i].e_stable = ((i - 23) < 5);
      tbl[i].e_trig   = 1'b0;
      tbl[i].e_busy   = 1'b0;
      tbl[i].e_count  = 4'd1;
    end

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].sw, tbl[i].rst);
      check("tbl_stable", sw_stable, tbl[i].e_stable);
      check("tbl_trig", trig_out, tbl[i].e_trig);
      check("tbl_busy", busy, tbl[i].e_busy);
      check("tbl_count", trig_count, tbl[i].e_count);
      check("tbl_overrun", overrun, 1'b0);
    end

    // Bounce: 1,1,0 then steady 1. Pulse starts 6 edges after the last 0->1.
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
    lat = -1; st_rises = 0; tr_rises = 0; prev_st = 1'b0; prev_tr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b0);
      if (trig_out && lat < 0) lat = i;
      if (sw_stable && !prev_st) st_rises++;
      if (trig_out && !prev_tr) tr_rises++;
      prev_st = sw_stable;
      prev_tr = trig_out;
    end
    check("bounce_latency", lat, 6);
    check("bounce_stable_rises", st_rises, 1);
    check("bounce_pulses", tr_rises, BN);
    check("bounce_count", trig_count, 1);

    // Overrun: the second clean rise reaches the FSM on the edge busy falls.
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    tr_rises = 0; prev_tr = 1'b0;
    for (int i = 0; i < 28; i++) begin
      cyc((i < 4 || i >= 8) ? 1'b1 : 1'b0, 1'b0);
      if (trig_out && !prev_tr) tr_rises++;
      prev_tr = trig_out;
    end
    check("overrun_flag", overrun, 1'b1);
    check("overrun_count", trig_count, 1);
    check("overrun_pulses", tr_rises, BN);

    // Short press: 3 high samples never pass the filter.
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    st_high = 0;
    for (int i = 0; i < 14; i++) begin
      cyc((i < 3) ? 1'b1 : 1'b0, 1'b0);
      if (sw_stable || trig_out) st_high++;
    end
    check("short_no_activity", st_high, 0);
    check("short_count", trig_count, 0);

    // Wrap: 16 accepted presses bring the counter back to 0.
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b0);
    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 22; i++) cyc((i < 10) ? 1'b1 : 1'b0, 1'b0);
      check("wrap_count", trig_count, (p + 1) % 16);
    end
    check("wrap_overrun", overrun, 1'b0);

    // Reset on the second trig_out cycle with SW held high.
    cyc(1'b1, 1'b0);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      cyc(1'b1, 1'b0);
      if (trig_out) lat = i;
    end
    check("rst_pulse_seen", (lat >= 0), 1'b1);
    cyc(1'b1, 1'b0);
    check("rst_second_cycle_high", trig_out, 1'b1);
    cyc(1'b1, 1'b1);
    check("rst_trig", trig_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_count", trig_count, 0);
    check("rst_stable", sw_stable, 1'b0);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0);
      if (trig_out && lat < 0) lat = i;
    end
    check("rst_retrigger_latency", lat, 6);
    check("rst_retrigger_count", trig_count, 1);

    // Randomized runs with occasional resets, checked against the model.
    cyc(1'b0, 1'b1);
    for (int r = 0; r < 120; r++) begin
      int   len;
      logic v;
      len = $urandom_range(1, 12);
      v   = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++)
        cyc(v, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
